// File: rtl/bitmap_sprite_engine.sv
// Multi-slot glyph sprite engine: pixel stream in, registered pixel-on/glyph/slot out after 3 cycles.
// Build macro SPRITE_BLINK_EN adds frame-counter blinking of slots selected by blinkMask.
module bitmap_sprite_engine #(
  parameter int WIDTH       = 240,
  parameter int HEIGHT      = 320,
  parameter int BITS_WIDTH  = 8,
  parameter int BITS_HEIGHT = 9,
  parameter int BITMAP_SIZE = 78,
  parameter int NUM_SLOTS   = 9,
  parameter int SLOT_BITS   = 4,
  parameter int BLINK_SHIFT = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic                   pixValid,
  input  logic [BITS_WIDTH-1:0]  xAddLCD,
  input  logic [BITS_HEIGHT-1:0] yAddLCD,
  input  logic                   cfgWrite,
  input  logic [SLOT_BITS-1:0]   cfgSlot,
  input  logic [1:0]             cfgGlyph,
  input  logic [BITS_WIDTH-1:0]  cfgX,
  input  logic [BITS_HEIGHT-1:0] cfgY,
  input  logic                   cfgClear,
  input  logic                   frameStart,
  input  logic [NUM_SLOTS-1:0]   blinkMask,
  output logic [6:0]             romAddress,
  output logic [1:0]             romGlyph,
  input  logic [BITMAP_SIZE-1:0] romData,
  output logic                   pixOutValid,
  output logic                   pixOn,
  output logic [1:0]             pixGlyph,
  output logic [SLOT_BITS-1:0]   pixSlot
);

  localparam int         RW      = 7;
  localparam logic [1:0] G_EMPTY = 2'd0;
  localparam logic       CFG_OK  = (WIDTH <= (1 << BITS_WIDTH)) && (HEIGHT <= (1 << BITS_HEIGHT)) &&
                                   (BLINK_SHIFT < 31) && (NUM_SLOTS <= (1 << SLOT_BITS));

  logic [BITS_WIDTH-1:0]  slot_x_q [NUM_SLOTS];
  logic [BITS_HEIGHT-1:0] slot_y_q [NUM_SLOTS];
  logic [1:0]             slot_g_q [NUM_SLOTS];

  // Slot indices that do not exist simply match no loop iteration; reserved glyph 3 is stored as empty.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slot_x_q[s] <= '0;
        slot_y_q[s] <= '0;
        slot_g_q[s] <= G_EMPTY;
      end
    end else if (cfgClear) begin
      for (int s = 0; s < NUM_SLOTS; s++) slot_g_q[s] <= G_EMPTY;
    end else if (cfgWrite) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (cfgSlot == SLOT_BITS'(s)) begin
          slot_x_q[s] <= cfgX;
          slot_y_q[s] <= cfgY;
          slot_g_q[s] <= (cfgGlyph == 2'd3) ? G_EMPTY : cfgGlyph;
        end
      end
    end
  end

  logic [NUM_SLOTS-1:0] blink_sup;
`ifdef SPRITE_BLINK_EN
  logic [BLINK_SHIFT:0] frame_cnt_q;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)         frame_cnt_q <= '0;
    else if (frameStart) frame_cnt_q <= frame_cnt_q + 1'b1;
  end
  assign blink_sup = frame_cnt_q[BLINK_SHIFT] ? blinkMask : '0;
  logic unused_cfg;
  assign unused_cfg = CFG_OK;
`else
  assign blink_sup = '0;
  logic unused_cfg;
  assign unused_cfg = ^{blinkMask, frameStart, CFG_OK};
`endif

  // S0: hit test at one extra bit so edge-straddling slots clip instead of wrapping; lowest index wins.
  logic                   hit_s0;
  logic [1:0]             glyph_s0;
  logic [SLOT_BITS-1:0]   slot_s0;
  logic [RW-1:0]          row_s0, col_s0;
  logic [BITS_WIDTH:0]    x_end;
  logic [BITS_HEIGHT:0]   y_end;

  always_comb begin
    hit_s0   = 1'b0;
    glyph_s0 = G_EMPTY;
    slot_s0  = '0;
    row_s0   = '0;
    col_s0   = '0;
    x_end    = '0;
    y_end    = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      x_end = {1'b0, slot_x_q[s]} + (BITS_WIDTH + 1)'(BITMAP_SIZE);
      y_end = {1'b0, slot_y_q[s]} + (BITS_HEIGHT + 1)'(BITMAP_SIZE);
      if (enable && (slot_g_q[s] != G_EMPTY) && !blink_sup[s] &&
          (xAddLCD >= slot_x_q[s]) && ({1'b0, xAddLCD} < x_end) &&
          (yAddLCD >= slot_y_q[s]) && ({1'b0, yAddLCD} < y_end)) begin
        hit_s0   = 1'b1;
        glyph_s0 = slot_g_q[s];
        slot_s0  = SLOT_BITS'(s);
        col_s0   = RW'(xAddLCD - slot_x_q[s]);
        row_s0   = RW'(yAddLCD - slot_y_q[s]);
      end
    end
  end

  logic                 vld_p1_q, hit_p1_q;
  logic [1:0]           glyph_p1_q;
  logic [SLOT_BITS-1:0] slot_p1_q;
  logic [RW-1:0]        row_p1_q, col_p1_q;
  logic                 vld_p2_q, hit_p2_q;
  logic [1:0]           glyph_p2_q;
  logic [SLOT_BITS-1:0] slot_p2_q;
  logic [RW-1:0]        col_p2_q;

  // S1 -> S2 -> S3: row/column are zero on a miss, so the ROM sees address 0 and glyph 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_p1_q    <= 1'b0;
      hit_p1_q    <= 1'b0;
      glyph_p1_q  <= '0;
      slot_p1_q   <= '0;
      row_p1_q    <= '0;
      col_p1_q    <= '0;
      vld_p2_q    <= 1'b0;
      hit_p2_q    <= 1'b0;
      glyph_p2_q  <= '0;
      slot_p2_q   <= '0;
      col_p2_q    <= '0;
      pixOutValid <= 1'b0;
      pixOn       <= 1'b0;
      pixGlyph    <= '0;
      pixSlot     <= '0;
    end else begin
      vld_p1_q    <= pixValid;
      hit_p1_q    <= hit_s0;
      glyph_p1_q  <= glyph_s0;
      slot_p1_q   <= slot_s0;
      row_p1_q    <= row_s0;
      col_p1_q    <= col_s0;
      vld_p2_q    <= vld_p1_q;
      hit_p2_q    <= hit_p1_q;
      glyph_p2_q  <= glyph_p1_q;
      slot_p2_q   <= slot_p1_q;
      col_p2_q    <= col_p1_q;
      pixOutValid <= vld_p2_q;
      pixOn       <= hit_p2_q & romData[col_p2_q];
      pixGlyph    <= glyph_p2_q;
      pixSlot     <= slot_p2_q;
    end
  end

  assign romAddress = row_p1_q;
  assign romGlyph   = glyph_p1_q;

endmodule

// File: tb/tb_bitmap_sprite_engine.sv
// Scoreboard bench for bitmap_sprite_engine: reference model + synchronous ROM model, per-scenario tasks.
`timescale 1ns/1ps
module tb_bitmap_sprite_engine;
  localparam int BW = 8, BH = 9, BS = 78, NS = 9, SB = 4;
`ifdef SPRITE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic          clock = 1'b0, resetn = 1'b0, enable = 1'b0, pixValid = 1'b0;
  logic [BW-1:0] xAddLCD = '0, cfgX = '0;
  logic [BH-1:0] yAddLCD = '0, cfgY = '0;
  logic          cfgWrite = 1'b0, cfgClear = 1'b0, frameStart = 1'b0;
  logic [SB-1:0] cfgSlot = '0;
  logic [1:0]    cfgGlyph = '0;
  logic [NS-1:0] blinkMask = '0;
  logic [6:0]    romAddress;
  logic [1:0]    romGlyph;
  logic [BS-1:0] romData;
  logic          pixOutValid, pixOn;
  logic [1:0]    pixGlyph;
  logic [SB-1:0] pixSlot;

  bitmap_sprite_engine dut (
    .clock(clock), .resetn(resetn), .enable(enable), .pixValid(pixValid),
    .xAddLCD(xAddLCD), .yAddLCD(yAddLCD), .cfgWrite(cfgWrite), .cfgSlot(cfgSlot),
    .cfgGlyph(cfgGlyph), .cfgX(cfgX), .cfgY(cfgY), .cfgClear(cfgClear),
    .frameStart(frameStart), .blinkMask(blinkMask), .romAddress(romAddress),
    .romGlyph(romGlyph), .romData(romData), .pixOutValid(pixOutValid), .pixOn(pixOn),
    .pixGlyph(pixGlyph), .pixSlot(pixSlot)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            cyc;
    logic          on;
    logic [1:0]    glyph;
    logic [SB-1:0] slot;
  } res_t;

  res_t       exp_q[$], obs_q[$];
  int         cyc = 0;
  int         n_checks = 0, n_fail = 0;
  int         m_x[NS], m_y[NS], m_frames;
  logic [1:0] m_g[NS];
  logic [NS-1:0] m_blink = '0;

  // Glyph ROM: row 0 all ones; cross = both diagonals; circle = ring of radius 30..38.
  function automatic logic [BS-1:0] rom_word(input logic [1:0] g, input int r);
    logic [BS-1:0] w;
    int d;
    for (int c = 0; c < BS; c++) begin
      d = (c - 39) * (c - 39) + (r - 39) * (r - 39);
      w[c] = (r == 0) || (g == 2'd1 && (c == r || c == BS - 1 - r)) ||
             (g == 2'd2 && d >= 900 && d <= 1444);
    end
    return w;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) romData <= rom_word(romGlyph, int'(romAddress));

  always @(negedge clock) begin
    res_t o;
    if (resetn && pixOutValid === 1'b1) begin
      o.cyc = cyc; o.on = pixOn; o.glyph = pixGlyph; o.slot = pixSlot;
      obs_q.push_back(o);
    end
  end

  function automatic res_t model(input int x, input int y, input logic en);
    res_t r;
    logic [BS-1:0] w;
    r.cyc = 0; r.on = 1'b0; r.glyph = 2'd0; r.slot = '0;
    for (int s = 0; s < NS; s++) begin
      if (en && m_g[s] != 2'd0 && !(BLINK && m_frames[4] && m_blink[s]) &&
          x >= m_x[s] && x < m_x[s] + BS && y >= m_y[s] && y < m_y[s] + BS) begin
        w = rom_word(m_g[s], y - m_y[s]);
        r.on = w[x - m_x[s]];
        r.glyph = m_g[s];
        r.slot = SB'(s);
        return r;
      end
    end
    return r;
  endfunction

  task automatic reset_model();
    for (int s = 0; s < NS; s++) begin
      m_x[s] = 0; m_y[s] = 0; m_g[s] = 2'd0;
    end
    m_frames = 0;
  endtask

  task automatic cfg_write(input int slot, input int g, input int x, input int y);
    cfgWrite = 1'b1; cfgSlot = SB'(slot); cfgGlyph = 2'(g); cfgX = BW'(x); cfgY = BH'(y);
    @(posedge clock); #1;
    cfgWrite = 1'b0;
    if (slot < NS) begin
      m_g[slot] = (g == 3) ? 2'd0 : 2'(g); m_x[slot] = x; m_y[slot] = y;
    end
  endtask

  task automatic drive_pix(input int x, input int y, input logic en);
    res_t r;
    xAddLCD = BW'(x); yAddLCD = BH'(y); enable = en; pixValid = 1'b1;
    r = model(x, y, en);
    r.cyc = cyc + 3;
    exp_q.push_back(r);
    @(posedge clock); #1;
    pixValid = 1'b0;
  endtask

  task automatic drain();
    pixValid = 1'b0;
    repeat (6) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    res_t e, o;
    reset_model();
    #12;
    n_checks++;
    if ({pixOutValid, pixOn, pixGlyph, pixSlot} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got vld=%b on=%b glyph=%0d slot=%0d, required all 0", pixOutValid, pixOn, pixGlyph, pixSlot);
    end
    n_checks++;
    if ({romAddress, romGlyph} !== '0) begin
      n_fail++; $display("FAIL reset_rom: got addr=%0d glyph=%0d, required 0", romAddress, romGlyph);
    end
    @(posedge clock); #1 resetn = 1'b1;
    drive_pix(0, 0, 1'b1);
    drive_pix(100, 100, 1'b1);
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL reset_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.cyc !== e.cyc || o.on !== e.on || o.glyph !== e.glyph || o.slot !== e.slot) begin
        n_fail++; $display("FAIL reset_scan: got cyc=%0d on=%b g=%0d s=%0d, required cyc=%0d on=%b g=%0d s=%0d", o.cyc, o.on, o.glyph, o.slot, e.cyc, e.on, e.glyph, e.slot);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_single_hit();
    res_t e, o;
    cfg_write(4, 1, 81, 121);
    drive_pix(81, 121, 1'b1);
    n_checks++;
    if (romAddress !== 7'd0 || romGlyph !== 2'd1) begin
      n_fail++; $display("FAIL single_rom: got addr=%0d glyph=%0d, required addr=0 glyph=1", romAddress, romGlyph);
    end
    drive_pix(82, 122, 1'b1);
    n_checks++;
    if (romAddress !== 7'd1) begin
      n_fail++; $display("FAIL single_rom_row1: got addr=%0d, required 1", romAddress);
    end
    drive_pix(83, 122, 1'b1);
    drive_pix(80, 121, 1'b1);
    drive_pix(81, 120, 1'b1);
    drive_pix(158, 198, 1'b1);
    drive_pix(159, 198, 1'b1);
    drive_pix(158, 199, 1'b1);
    drive_pix(157, 198, 1'b1);
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL single_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.cyc !== e.cyc || o.on !== e.on || o.glyph !== e.glyph || o.slot !== e.slot) begin
        n_fail++; $display("FAIL single_scan: got cyc=%0d on=%b g=%0d s=%0d, required cyc=%0d on=%b g=%0d s=%0d", o.cyc, o.on, o.glyph, o.slot, e.cyc, e.on, e.glyph, e.slot);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_priority();
    res_t e, o;
    cfg_write(0, 2, 0, 0);
    cfg_write(1, 1, 0, 0);
    drive_pix(10, 10, 1'b1);
    drive_pix(1, 39, 1'b1);
    cfgClear = 1'b1; cfgWrite = 1'b1; cfgSlot = 4'd1; cfgGlyph = 2'd1; cfgX = '0; cfgY = '0;
    @(posedge clock); #1;
    cfgClear = 1'b0; cfgWrite = 1'b0;
    for (int s = 0; s < NS; s++) m_g[s] = 2'd0;
    drive_pix(10, 10, 1'b1);
    drive_pix(81, 121, 1'b1);
    cfg_write(9, 1, 0, 0);
    cfg_write(3, 3, 0, 0);
    drive_pix(0, 0, 1'b1);
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL prio_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.cyc !== e.cyc || o.on !== e.on || o.glyph !== e.glyph || o.slot !== e.slot) begin
        n_fail++; $display("FAIL prio_scan: got cyc=%0d on=%b g=%0d s=%0d, required cyc=%0d on=%b g=%0d s=%0d", o.cyc, o.on, o.glyph, o.slot, e.cyc, e.on, e.glyph, e.slot);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clip_and_timing();
    res_t e, o, r;
    cfg_write(2, 2, 200, 300);
    drive_pix(239, 319, 1'b1);
    n_checks++;
    if (romAddress !== 7'd19 || romGlyph !== 2'd2) begin
      n_fail++; $display("FAIL clip_rom: got addr=%0d glyph=%0d, required addr=19 glyph=2", romAddress, romGlyph);
    end
    drive_pix(239, 300, 1'b1);
    drive_pix(200, 300, 1'b1);
    drive_pix(10, 10, 1'b0);
    // config write and pixel in the same cycle: the pixel must see the old configuration
    cfgWrite = 1'b1; cfgSlot = 4'd6; cfgGlyph = 2'd1; cfgX = 8'd10; cfgY = 9'd10;
    xAddLCD = 8'd10; yAddLCD = 9'd10; enable = 1'b1; pixValid = 1'b1;
    r = model(10, 10, 1'b1); r.cyc = cyc + 3; exp_q.push_back(r);
    @(posedge clock); #1;
    cfgWrite = 1'b0; pixValid = 1'b0;
    m_g[6] = 2'd1; m_x[6] = 10; m_y[6] = 10;
    drive_pix(10, 10, 1'b1);
    drive_pix(10, 10, 1'b0);
    drive_pix(11, 11, 1'b1);
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL clip_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.cyc !== e.cyc || o.on !== e.on || o.glyph !== e.glyph || o.slot !== e.slot) begin
        n_fail++; $display("FAIL clip_scan: got cyc=%0d on=%b g=%0d s=%0d, required cyc=%0d on=%b g=%0d s=%0d", o.cyc, o.on, o.glyph, o.slot, e.cyc, e.on, e.glyph, e.slot);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t e, o;
    int k, x, y;
    int bases[4] = '{0, 2, 3, 8};
    cfg_write(0, 1, 20, 30);
    cfg_write(3, 2, 50, 60);
    cfg_write(8, 1, 180, 240);
    for (int i = 0; i < 300; i++) begin
      k = bases[$urandom_range(0, 3)];
      x = m_x[k] + int'($urandom_range(0, 85)) - 4;
      y = m_y[k] + int'($urandom_range(0, 85)) - 4;
      if (x < 0) x = 0;
      if (x > 239) x = 239;
      if (y < 0) y = 0;
      if (y > 319) y = 319;
      drive_pix(x, y, ($urandom_range(0, 7) != 0));
    end
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.cyc !== e.cyc || o.on !== e.on || o.glyph !== e.glyph || o.slot !== e.slot) begin
        n_fail++; $display("FAIL b2b_scan: got cyc=%0d on=%b g=%0d s=%0d, required cyc=%0d on=%b g=%0d s=%0d", o.cyc, o.on, o.glyph, o.slot, e.cyc, e.on, e.glyph, e.slot);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midstream();
    res_t e, o;
    cfg_write(4, 1, 81, 121);
    for (int i = 0; i < 5; i++) drive_pix(81, 121, 1'b1);
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if ({pixOutValid, pixOn, pixGlyph, pixSlot} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got vld=%b on=%b glyph=%0d slot=%0d, required all 0", pixOutValid, pixOn, pixGlyph, pixSlot);
    end
    n_checks++;
    if ({romAddress, romGlyph} !== '0) begin
      n_fail++; $display("FAIL midreset_rom: got addr=%0d glyph=%0d, required 0", romAddress, romGlyph);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.cyc !== e.cyc || o.on !== e.on || o.glyph !== e.glyph || o.slot !== e.slot) begin
        n_fail++; $display("FAIL midreset_pre: got cyc=%0d on=%b g=%0d s=%0d, required cyc=%0d on=%b g=%0d s=%0d", o.cyc, o.on, o.glyph, o.slot, e.cyc, e.on, e.glyph, e.slot);
      end
    end
    exp_q.delete(); obs_q.delete();
    reset_model();
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL midreset_stale: got %0d valid results after release, required 0", obs_q.size());
    end
    obs_q.delete();
    drive_pix(81, 121, 1'b1);
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midreset_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.cyc !== e.cyc || o.on !== e.on || o.glyph !== e.glyph || o.slot !== e.slot) begin
        n_fail++; $display("FAIL midreset_post: got cyc=%0d on=%b g=%0d s=%0d, required cyc=%0d on=%b g=%0d s=%0d", o.cyc, o.on, o.glyph, o.slot, e.cyc, e.on, e.glyph, e.slot);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_blink();
    res_t e, o;
    cfg_write(4, 1, 81, 121);
    cfg_write(5, 2, 81, 121);
    m_blink = 9'b0_0001_0000;
    blinkMask = m_blink;
    for (int i = 0; i < 40; i++) begin
      frameStart = 1'b1;
      @(posedge clock); #1;
      frameStart = 1'b0;
      m_frames++;
      drive_pix(81, 121, 1'b1);
    end
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL blink_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.cyc !== e.cyc || o.on !== e.on || o.glyph !== e.glyph || o.slot !== e.slot) begin
        n_fail++; $display("FAIL blink_scan: got cyc=%0d on=%b g=%0d s=%0d, required cyc=%0d on=%b g=%0d s=%0d", o.cyc, o.on, o.glyph, o.slot, e.cyc, e.on, e.glyph, e.slot);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_hit();
    test_priority();
    test_clip_and_timing();
    test_back_to_back();
    test_reset_midstream();
    test_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitmap_sprite_engine.md
# bitmap_sprite_engine

Multi-slot, pipelined successor to the single-glyph bitmap generator for the Tic Tac Toe LCD renderer. It holds a position and glyph (empty/cross/circle) for each board cell. For each pixel coordinate streamed from the LCD scan logic it looks up the shared glyph ROM and returns a registered pixel-on flag, glyph id and slot index after a fixed latency. It sits between the LCD pixel scanner and the colour mux, replacing per-cell generator instances.

## Interface
- WIDTH, 240: LCD width in pixels
- HEIGHT, 320: LCD height in pixels
- BITS_WIDTH, 8: x coordinate width
- BITS_HEIGHT, 9: y coordinate width
- BITMAP_SIZE, 78: square glyph edge in pixels; also the ROM word width and depth
- NUM_SLOTS, 9: number of sprite slots
- SLOT_BITS, 4: width of slot index, ≥ clog2(NUM_SLOTS)
- BLINK_SHIFT, 4: blink frame-counter bit (blink build only)

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  global draw enable; sampled with the pixel
- pixValid  in  1  pixel coordinate valid
- xAddLCD  in  BITS_WIDTH  pixel x
- yAddLCD  in  BITS_HEIGHT  pixel y
- cfgWrite  in  1  write one slot
- cfgSlot  in  SLOT_BITS  slot to write
- cfgGlyph  in  2  0 empty, 1 cross, 2 circle, 3 reserved (treated as empty)
- cfgX  in  BITS_WIDTH  slot top-left x
- cfgY  in  BITS_HEIGHT  slot top-left y
- cfgClear  in  1  set every slot to empty
- frameStart  in  1  one-cycle pulse per LCD frame
- blinkMask  in  NUM_SLOTS  slots to blink (blink build only)
- romAddress  out  7  glyph ROM row
- romGlyph  out  2  glyph ROM select
- romData  in  BITMAP_SIZE  ROM word; synchronous, 1-cycle read latency
- pixOutValid  out  1  result valid
- pixOn  out  1  pixel is inside a glyph and its bitmap bit is set
- pixGlyph  out  2  glyph of the winning slot, 0 if no hit
- pixSlot  out  SLOT_BITS  index of the winning slot, 0 if no hit

## Operation
- Slot registers: x, y, glyph per slot. Reset value is empty at position (0,0).
- cfgClear and cfgWrite in the same cycle: clear wins. A cfgSlot ≥ NUM_SLOTS is ignored.
- Hit test for slot s: glyph non-empty, x ≤ xAddLCD < x+BITMAP_SIZE, y ≤ yAddLCD < y+BITMAP_SIZE.
- Hit sums are computed at BITS+1 width so they never wrap. A slot straddling the screen edge clips correctly.
- Overlapping hits: the lowest slot index wins.
- Row = yAddLCD − y. Column = xAddLCD − x. Row 0 is the top. Bitmap bit for a column is romData[column].
- With no hit, romAddress and romGlyph are 0 and the result is pixOn=0, pixGlyph=0, pixSlot=0.
- With enable low, the hit is forced off. pixOutValid still follows pixValid.
- Pipeline stages:
  - S0 (input): hit test and priority encode.
  - S1: register valid, hit, glyph, slot, row, column. Drive romAddress and romGlyph from the S1 registers.
  - S2: romData arrives; the S1 fields advance alongside.
  - S3: output register, pixOn = hit & romData[column].
- There is no back-pressure. A pixel is accepted every cycle.

## Timing
- Latency is fixed at 3. pixValid at cycle t gives pixOutValid at t+3. Full throughput with no bubbles.
- A config write at cycle t affects pixels sampled from t+1. A pixel sampled at t uses the old config.
- Reset, including mid-stream: all pipeline valids, outputs, romAddress, romGlyph and slot registers go to 0 immediately. In-flight pixels are dropped.

## Configuration
- SPRITE_BLINK_EN defined:
  - An internal frame counter increments on each frameStart.
  - While counter bit BLINK_SHIFT is 1, hits for slots set in blinkMask are suppressed. A lower-priority overlapping slot may then win.
  - The counter resets to 0.
- SPRITE_BLINK_EN undefined: the counter is not built, blinkMask and BLINK_SHIFT are ignored, and the block is otherwise identical.

## Test plan
- Write slot 4 = cross at (81,121); scan (81,121) with a ROM model whose row 0 = all ones → pixOutValid 3 cycles later, pixOn=1, pixGlyph=1, pixSlot=4, romAddress=0.
- Scan (158,198) and (159,198) against slot 4 → the first hits row 77, column 77; the second gives pixOn=0, pixGlyph=0.
- Slot 0 = circle and slot 1 = cross, both at (0,0); scan (10,10) → pixSlot=0, pixGlyph=2. Then cfgClear and cfgWrite of slot 1 in the same cycle → all slots empty.
- Slot at (200,300) and scan (239,319) → hit at column 39, row 19 with no wrap. Assert resetn mid-stream → outputs 0 immediately, no stale valid after release.
- With SPRITE_BLINK_EN, blinkMask bit 4 set and 16 frameStart pulses → slot 4 suppressed while counter bit 4 = 1, visible otherwise. Without the macro, slot 4 is always visible.
